memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM stage of the 64-bit RV64 pipeline; consumes the EX/MEM register outputs from the execute stage.
- Issues loads and stores to data memory over a single-outstanding req/ack bus.
- Stalls upstream while an access is in flight, then registers MEM/WB outputs for the writeback stage.
- Performs store byte-lane steering and load extraction with sign/zero extension.

Parameters:
XLEN, 64, datapath and address width
STRB_W, 8, byte strobes per data word (XLEN/8)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
reg_write_e  input  1  destination register write enable from EX
result_src_e  input  2  00 ALU, 01 load data, 10 pc+4, 11 reserved (treated as ALU)
mem_write_e  input  1  store request
funct3_e  input  3  access size/sign
alu_result  input  64  effective address or ALU value
write_data  input  64  store data (rs2)
destination_register_e  input  5  rd
pc_plus4_e  input  64  link value
stall_m  output  1  combinational; upstream holds EX/MEM inputs while high
dmem_req  output  1  registered request; held until ack
dmem_we  output  1  1 store, 0 load
dmem_addr  output  64  doubleword-aligned address {alu_result[63:3],3'b000}
dmem_wdata  output  64  store data shifted to byte lane
dmem_wstrb  output  8  byte enables (all 0 for loads)
dmem_ack  input  1  access complete; rdata valid same cycle
dmem_rdata  input  64  read doubleword
reg_write_m  output  1  to WB
result_src_m  output  2  to WB
read_data_m  output  64  extended load data
alu_result_m  output  64  to WB
destination_register_m  output  5  to WB
pc_plus4_m  output  64  to WB
misaligned_m  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_wstrb, and all *_m outputs 0. Reset mid-access abandons the access: dmem_req is 0 after the reset edge, and a later ack is ignored.
- mem_op = mem_write_e | (result_src_e==01).
- State IDLE:
  - If !mem_op: stall_m=0; on the edge, capture all *_m from inputs. Latency is 1 cycle.
  - If mem_op: stall_m=1; on the edge, go to ACCESS and register dmem_req=1, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb. Capture funct3, addr[2:0], and the pass-through fields internally. *_m become a bubble (reg_write_m=0, others hold).
- State ACCESS:
  - stall_m = !dmem_ack.
  - On an edge with dmem_ack=1: dmem_req←0, state←IDLE, *_m←captured fields, read_data_m←extended rdata (0 for stores). Minimum memory latency is 2 cycles.
  - Without ack: request fields hold stable and *_m stay a bubble.
- dmem_ack in IDLE is ignored.
- Store lanes, by funct3: 0 SB wstrb=1<<a; 1 SH 3<<a; 2 SW 0xF<<a; 3 SD 0xFF. Here a=addr[2:0], and wdata=write_data<<(8*a).
- Load extraction, by funct3: shift rdata right by 8*a, then:
  - 0 LB: sign-extend 8 bits
  - 1 LH: sign-extend 16 bits
  - 2 LW: sign-extend 32 bits
  - 3 LD: full 64 bits
  - 4 LBU, 5 LHU, 6 LWU: zero-extend
  - 7: treat as LD.
- Store funct3 4..7 is treated as SD.
- mem_write_e and result_src_e==01 together: performed as a store; read_data_m=0.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned mem_op (H with a[0]≠0, W with a[1:0]≠0, D with a≠0) issues no bus request.
  - Takes the non-memory 1-cycle path with reg_write_m=0 and misaligned_m=1 for that one result.
- Undefined:
  - misaligned_m is tied 0.
  - a is masked to natural alignment (H clears bit0, W clears bits1:0, D uses a=0) before lane and strobe computation.

Decomposition:
- Shared package riscv_pkg:
  - result_src encodings RES_ALU/RES_MEM/RES_PC4
  - funct3 constants F3_B/H/W/D/BU/HU/WU
  - mem_state_t {IDLE, ACCESS}
  - XLEN
- One sub-module load_extend: combinational rdata, a, funct3 → read value.

Test Plan:
- ADD pass-through: result_src=00, alu_result=0x1234, rd=5, reg_write=1 → next cycle alu_result_m=0x1234, reg_write_m=1, no dmem_req, stall_m never high.
- LB sign: addr=0x1003, dmem_rdata=0x00000000_80000000, ack 3 cycles after req → dmem_addr=0x1000, stall_m high 4 cycles, read_data_m=0xFFFF_FFFF_FFFF_FF80.
- SH lanes: addr=0x2006, write_data=0xBEEF, ack same cycle as req → dmem_wstrb=0xC0, dmem_wdata=0xBEEF<<48, reg_write_m=0, 2-cycle total.
- LWU zero-extend: addr=0x4, rdata=0xF234_5678_0000_0000 → read_data_m=0x0000_0000_F234_5678.
- Reset mid-ACCESS: reset asserted while dmem_req=1 awaiting ack, late ack next cycle → dmem_req=0, all *_m=0, ack ignored, next ALU op completes normally.
- With MEM_MISALIGN_TRAP_EN: LW at addr=0x2 → no dmem_req, misaligned_m=1 for one cycle, reg_write_m=0; without the macro, dmem_wstrb/extraction use a=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: widths, result-source and funct3
// encodings, MEM stage FSM states and access-size helpers.
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // log2 of the access size in bytes. Stores with funct3 4..7 are
  // doubleword; loads map 4/5/6 onto B/H/W and 7 onto D via the low bits.
  function automatic logic [1:0] access_size(input logic [2:0] funct3,
                                             input logic       is_store);
    if (is_store && funct3[2]) return 2'd3;
    return funct3[1:0];
  endfunction

  // Byte-offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Load data extraction: moves the addressed bytes of a doubleword down to
// bit 0 and sign- or zero-extends them according to funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      a_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] value_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {a_i, 3'b000};

  // Select width and extension; funct3 7 falls through to the full doubleword.
  always_comb begin
    case (funct3_i)
      F3_B:    value_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    value_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    value_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   value_o = {56'd0, shifted[7:0]};
      F3_HU:   value_o = {48'd0, shifted[15:0]};
      F3_WU:   value_o = {32'd0, shifted[31:0]};
      default: value_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV64 MEM stage: issues one load/store at a time on a req/ack data bus,
// stalls upstream while it is in flight, and registers the MEM/WB outputs.
// Build option MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and
// raise misaligned_m; otherwise the offset is forced to natural alignment.
module memory_stage
  import riscv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_write_e,
  input  logic [1:0]        result_src_e,
  input  logic              mem_write_e,
  input  logic [2:0]        funct3_e,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   write_data,
  input  logic [4:0]        destination_register_e,
  input  logic [XLEN-1:0]   pc_plus4_e,
  output logic              stall_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              reg_write_m,
  output logic [1:0]        result_src_m,
  output logic [XLEN-1:0]   read_data_m,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [4:0]        destination_register_m,
  output logic [XLEN-1:0]   pc_plus4_m,
  output logic              misaligned_m
);

  mem_state_t        state_q, state_d;

  logic              mem_op, take_access, misal_trap;
  logic [1:0]        size;
  logic [2:0]        mask, a_eff;
  logic [STRB_W-1:0] wstrb_calc;
  logic [XLEN-1:0]   wdata_calc, load_value;

  // Bus request registers
  logic              dmem_req_q, dmem_we_q;
  logic [XLEN-1:0]   dmem_addr_q, dmem_wdata_q;
  logic [STRB_W-1:0] dmem_wstrb_q;

  // Fields captured at issue and released to WB when the access completes
  logic [2:0]        f3_q, a_q;
  logic              is_store_q, cap_reg_write_q;
  logic [1:0]        cap_result_src_q;
  logic [XLEN-1:0]   cap_alu_q, cap_pc4_q;
  logic [4:0]        cap_rd_q;

  // MEM/WB registers
  logic              reg_write_m_q, misaligned_q;
  logic [1:0]        result_src_m_q;
  logic [XLEN-1:0]   read_data_m_q, alu_result_m_q, pc_plus4_m_q;
  logic [4:0]        rd_m_q;

  assign mem_op = mem_write_e | (result_src_e == RES_MEM);
  assign size   = access_size(funct3_e, mem_write_e);
  assign mask   = align_mask(size);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal_trap = mem_op & (|(alu_result[2:0] & mask));
  assign a_eff      = alu_result[2:0];
`else
  assign misal_trap = 1'b0;
  assign a_eff      = alu_result[2:0] & ~mask;
`endif

  assign take_access = mem_op & ~misal_trap;

  // Store lane steering; loads drive no strobes.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    wstrb_calc = '0;
    if (mem_write_e) begin
      case (size)
        2'd0:    wstrb_calc = 8'h01 << a_eff;
        2'd1:    wstrb_calc = 8'h03 << a_eff;
        2'd2:    wstrb_calc = 8'h0F << a_eff;
        default: wstrb_calc = 8'hFF;
      endcase
    end
  end

  assign wdata_calc = write_data << {a_eff, 3'b000};

  load_extend u_load_extend (
    .rdata_i  (dmem_rdata),
    .a_i      (a_q),
    .funct3_i (f3_q),
    .value_o  (load_value)
  );

  // Next state and upstream stall.
  always_comb begin
    state_d = state_q;
    stall_m = 1'b0;
    case (state_q)
      IDLE: begin
        stall_m = take_access;
        if (take_access) state_d = ACCESS;
      end
      ACCESS: begin
        stall_m = ~dmem_ack;
        if (dmem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequential state: bus request, captured fields and MEM/WB registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q          <= IDLE;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wdata_q     <= '0;
      dmem_wstrb_q     <= '0;
      f3_q             <= '0;
      a_q              <= '0;
      is_store_q       <= 1'b0;
      cap_reg_write_q  <= 1'b0;
      cap_result_src_q <= '0;
      cap_alu_q        <= '0;
      cap_pc4_q        <= '0;
      cap_rd_q         <= '0;
      reg_write_m_q    <= 1'b0;
      misaligned_q     <= 1'b0;
      result_src_m_q   <= '0;
      read_data_m_q    <= '0;
      alu_result_m_q   <= '0;
      pc_plus4_m_q     <= '0;
      rd_m_q           <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (take_access) begin
            dmem_req_q       <= 1'b1;
            dmem_we_q        <= mem_write_e;
            dmem_addr_q      <= {alu_result[XLEN-1:3], 3'b000};
            dmem_wdata_q     <= wdata_calc;
            dmem_wstrb_q     <= wstrb_calc;
            f3_q             <= funct3_e;
            a_q              <= a_eff;
            is_store_q       <= mem_write_e;
            cap_reg_write_q  <= reg_write_e;
            cap_result_src_q <= result_src_e;
            cap_alu_q        <= alu_result;
            cap_pc4_q        <= pc_plus4_e;
            cap_rd_q         <= destination_register_e;
            reg_write_m_q    <= 1'b0;
            misaligned_q     <= 1'b0;
          end else begin
            reg_write_m_q  <= reg_write_e & ~misal_trap;
            misaligned_q   <= misal_trap;
            result_src_m_q <= result_src_e;
            read_data_m_q  <= '0;
            alu_result_m_q <= alu_result;
            pc_plus4_m_q   <= pc_plus4_e;
            rd_m_q         <= destination_register_e;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req_q     <= 1'b0;
            reg_write_m_q  <= cap_reg_write_q;
            result_src_m_q <= cap_result_src_q;
            read_data_m_q  <= is_store_q ? '0 : load_value;
            alu_result_m_q <= cap_alu_q;
            pc_plus4_m_q   <= cap_pc4_q;
            rd_m_q         <= cap_rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req               = dmem_req_q;
  assign dmem_we                = dmem_we_q;
  assign dmem_addr              = dmem_addr_q;
  assign dmem_wdata             = dmem_wdata_q;
  assign dmem_wstrb             = dmem_wstrb_q;
  assign reg_write_m            = reg_write_m_q;
  assign result_src_m           = result_src_m_q;
  assign read_data_m            = read_data_m_q;
  assign alu_result_m           = alu_result_m_q;
  assign destination_register_m = rd_m_q;
  assign pc_plus4_m             = pc_plus4_m_q;
  assign misaligned_m           = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected MEM/WB results are queued when
// an operation is driven and compared when the stage retires it.
module tb_memory_stage;
  import riscv_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              reg_write_e, mem_write_e;
  logic [1:0]        result_src_e;
  logic [2:0]        funct3_e;
  logic [63:0]       alu_result, write_data, pc_plus4_e;
  logic [4:0]        destination_register_e;
  logic              stall_m, dmem_req, dmem_we, dmem_ack;
  logic [63:0]       dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]        dmem_wstrb;
  logic              reg_write_m, misaligned_m;
  logic [1:0]        result_src_m;
  logic [63:0]       read_data_m, alu_result_m, pc_plus4_m;
  logic [4:0]        destination_register_m;

  typedef struct {
    string       tag;
    logic        rw;
    logic [1:0]  rs;
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [63:0] pc4;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  memory_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .reg_write_e            (reg_write_e),
    .result_src_e           (result_src_e),
    .mem_write_e            (mem_write_e),
    .funct3_e               (funct3_e),
    .alu_result             (alu_result),
    .write_data             (write_data),
    .destination_register_e (destination_register_e),
    .pc_plus4_e             (pc_plus4_e),
    .stall_m                (stall_m),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_wstrb             (dmem_wstrb),
    .dmem_ack               (dmem_ack),
    .dmem_rdata             (dmem_rdata),
    .reg_write_m            (reg_write_m),
    .result_src_m           (result_src_m),
    .read_data_m            (read_data_m),
    .alu_result_m           (alu_result_m),
    .destination_register_m (destination_register_m),
    .pc_plus4_m             (pc_plus4_m),
    .misaligned_m           (misaligned_m)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [2:0] f3, input logic [63:0] alu,
                        input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] pc4);
    reg_write_e            = rw;
    result_src_e           = rs;
    mem_write_e            = mw;
    funct3_e               = f3;
    alu_result             = alu;
    write_data             = wd;
    destination_register_e = rd;
    pc_plus4_e             = pc4;
  endtask

  task automatic push_exp(input string tag, input logic rw, input logic [1:0] rs,
                          input logic [63:0] rdata, input logic [63:0] alu,
                          input logic [4:0] rd, input logic [63:0] pc4, input logic mis);
    exp_t e;
    e.tag = tag; e.rw = rw; e.rs = rs; e.rdata = rdata;
    e.alu = alu; e.rd = rd; e.pc4 = pc4; e.mis = mis;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_empty: observed no queued result expected one");
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_reg_write_m"}, reg_write_m, e.rw);
    check({e.tag, "_result_src_m"}, result_src_m, e.rs);
    check({e.tag, "_read_data_m"}, read_data_m, e.rdata);
    check({e.tag, "_alu_result_m"}, alu_result_m, e.alu);
    check({e.tag, "_rd_m"}, destination_register_m, e.rd);
    check({e.tag, "_pc_plus4_m"}, pc_plus4_m, e.pc4);
    check({e.tag, "_misaligned_m"}, misaligned_m, e.mis);
  endtask

  // One-cycle non-memory operation.
  task automatic alu_step(input string tag, input logic rw, input logic [1:0] rs,
                          input logic [63:0] alu, input logic [4:0] rd,
                          input logic [63:0] pc4);
    @(negedge clock);
    set_op(rw, rs, 1'b0, 3'd0, alu, 64'h0, rd, pc4);
    #1 check({tag, "_stall"}, stall_m, 1'b0);
    push_exp(tag, rw, rs, 64'h0, alu, rd, pc4, 1'b0);
    @(posedge clock);
    #1 check({tag, "_no_req"}, dmem_req, 1'b0);
    compare_out();
  endtask

  // Memory operation acknowledged after wait_n request cycles without ack.
  task automatic mem_step(input string tag, input logic rw, input logic [1:0] rs,
                          input logic mw, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] wd,
                          input logic [4:0] rd, input logic [63:0] pc4,
                          input int wait_n, input logic [63:0] rdata,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_wstrb, input logic [63:0] exp_read);
    int stall_cnt = 0;
    @(negedge clock);
    set_op(rw, rs, mw, f3, alu, wd, rd, pc4);
    #1 if (stall_m) stall_cnt++;
    push_exp(tag, rw, rs, exp_read, alu, rd, pc4, 1'b0);
    @(posedge clock);
    #1;
    check({tag, "_req"}, dmem_req, 1'b1);
    check({tag, "_we"}, dmem_we, mw);
    check({tag, "_addr"}, dmem_addr, exp_addr);
    check({tag, "_wstrb"}, dmem_wstrb, exp_wstrb);
    if (mw) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
    check({tag, "_bubble"}, reg_write_m, 1'b0);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clock);
      #1 if (stall_m) stall_cnt++;
      @(posedge clock);
    end
    if (wait_n > 0) begin
      #1;
      check({tag, "_req_hold"}, dmem_req, 1'b1);
      check({tag, "_addr_hold"}, dmem_addr, exp_addr);
      check({tag, "_bubble_hold"}, reg_write_m, 1'b0);
    end
    @(negedge clock);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1 if (stall_m) stall_cnt++;
    @(posedge clock);
    #1 dmem_ack = 1'b0;
    check({tag, "_req_drop"}, dmem_req, 1'b0);
    check({tag, "_stall_cycles"}, stall_cnt, 1 + wait_n);
    compare_out();
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 64'h0;
    set_op(1'b0, 2'b00, 1'b0, 3'd0, 64'h0, 64'h0, 5'd0, 64'h0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_wstrb", dmem_wstrb, 8'h00);
    check("rst_reg_write_m", reg_write_m, 1'b0);
    check("rst_alu_result_m", alu_result_m, 64'h0);
    check("rst_read_data_m", read_data_m, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    alu_step("add", 1'b1, RES_ALU, 64'h1234, 5'd5, 64'h100);
    mem_step("lb", 1'b1, RES_MEM, 1'b0, F3_B, 64'h1003, 64'h0, 5'd6, 64'h104,
             3, 64'h0000_0000_8000_0000, 64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    mem_step("sh", 1'b0, RES_ALU, 1'b1, F3_H, 64'h2006, 64'hBEEF, 5'd0, 64'h108,
             0, 64'h0, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0);
    mem_step("lwu", 1'b1, RES_MEM, 1'b0, F3_WU, 64'h4, 64'h0, 5'd7, 64'h10C,
             1, 64'hF234_5678_0000_0000, 64'h0, 64'h0, 8'h00, 64'h0000_0000_F234_5678);
    mem_step("ld", 1'b1, RES_MEM, 1'b0, F3_D, 64'h18, 64'h0, 5'd8, 64'h110,
             2, 64'h8765_4321_0FED_CBA9, 64'h18, 64'h0, 8'h00, 64'h8765_4321_0FED_CBA9);
    mem_step("lh", 1'b1, RES_MEM, 1'b0, F3_H, 64'h22, 64'h0, 5'd9, 64'h114,
             0, 64'h0000_0000_8001_0000, 64'h20, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
    mem_step("sb", 1'b0, RES_ALU, 1'b1, F3_B, 64'h3005, 64'hFFFF_FFFF_FFFF_FFAB, 5'd0, 64'h118,
             1, 64'h0, 64'h3000, 64'hFFFF_AB00_0000_0000, 8'h20, 64'h0);
    mem_step("sd_f3_5", 1'b0, RES_ALU, 1'b1, F3_HU, 64'h48, 64'h0123_4567_89AB_CDEF, 5'd0, 64'h11C,
             0, 64'h0, 64'h48, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0);
    mem_step("st_and_ld", 1'b1, RES_MEM, 1'b1, F3_W, 64'h10, 64'h1111_2222_3333_4444, 5'd10, 64'h120,
             1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h1111_2222_3333_4444, 8'h0F, 64'h0);
    alu_step("pc4", 1'b1, RES_PC4, 64'h55, 5'd1, 64'h200);

    // Ack while idle must not create a request or disturb the result.
    @(negedge clock);
    dmem_ack = 1'b1;
    set_op(1'b1, RES_ALU, 1'b0, 3'd0, 64'h77, 64'h0, 5'd2, 64'h204);
    push_exp("idle_ack", 1'b1, RES_ALU, 64'h0, 64'h77, 5'd2, 64'h204, 1'b0);
    @(posedge clock);
    #1 dmem_ack = 1'b0;
    check("idle_ack_no_req", dmem_req, 1'b0);
    compare_out();

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clock);
    set_op(1'b1, RES_MEM, 1'b0, F3_W, 64'h2, 64'h0, 5'd3, 64'h208);
    #1 check("mis_lw_stall", stall_m, 1'b0);
    push_exp("mis_lw", 1'b0, RES_MEM, 64'h0, 64'h2, 5'd3, 64'h208, 1'b1);
    @(posedge clock);
    #1 check("mis_lw_no_req", dmem_req, 1'b0);
    compare_out();
    alu_step("mis_after", 1'b1, RES_ALU, 64'h99, 5'd4, 64'h20C);
`else
    mem_step("lw_masked", 1'b1, RES_MEM, 1'b0, F3_W, 64'h2, 64'h0, 5'd3, 64'h208,
             0, 64'h1111_2222_8000_0004, 64'h0, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0004);
    mem_step("sw_masked", 1'b0, RES_ALU, 1'b1, F3_W, 64'h6, 64'h0000_0000_CAFE_F00D, 5'd0, 64'h20C,
             0, 64'h0, 64'h0, 64'hCAFE_F00D_0000_0000, 8'hF0, 64'h0);
`endif

    // Reset while an access awaits ack; the late ack must be ignored.
    @(negedge clock);
    set_op(1'b1, RES_MEM, 1'b0, F3_D, 64'h30, 64'h0, 5'd11, 64'h300);
    @(posedge clock);
    #1 check("rst_mid_req_up", dmem_req, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    set_op(1'b0, RES_ALU, 1'b0, 3'd0, 64'h0, 64'h0, 5'd0, 64'h0);
    @(posedge clock);
    #1;
    check("rst_mid_req", dmem_req, 1'b0);
    check("rst_mid_reg_write_m", reg_write_m, 1'b0);
    check("rst_mid_alu_result_m", alu_result_m, 64'h0);
    check("rst_mid_rd_m", destination_register_m, 5'd0);
    check("rst_mid_pc_plus4_m", pc_plus4_m, 64'h0);
    check("rst_mid_result_src_m", result_src_m, 2'b00);
    check("rst_mid_read_data_m", read_data_m, 64'h0);
    @(negedge clock);
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1 check("late_ack_stall", stall_m, 1'b0);
    @(posedge clock);
    #1 dmem_ack = 1'b0;
    check("late_ack_req", dmem_req, 1'b0);
    check("late_ack_read_data_m", read_data_m, 64'h0);
    check("late_ack_reg_write_m", reg_write_m, 1'b0);
    alu_step("post_rst_add", 1'b1, RES_ALU, 64'hABCD, 5'd12, 64'h304);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
